// File: rtl/hazard_stall_controller_if.sv
// ============================================================================
// Module      : hazard_stall_controller_if
// Description : Pipeline-control bundle between the 5-stage datapath and the
//               hazard/stall controller. The datapath side uses the master
//               modport and the controller uses the slave modport.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hazard_stall_controller_if;
  // Hazard-detection inputs coming from the ID and EX stages
  logic [4:0]  IDRS;
  logic [4:0]  IDRT;
  logic        IDUsesRT;
  logic [4:0]  EXRT;
  logic        EXMemRead;
  logic        EXMulDiv;
  logic        BranchTaken;

  // Pipeline-control outputs produced by the controller
  logic        PCWrite;
  logic        IFIDWrite;
  logic        IDEXWrite;
  logic        IFIDFlush;
  logic        IDEXFlush;
  logic        EXMEMBubble;
  logic        MulDivBusy;
  logic        MulDivDone;
  logic [31:0] StallCycles;

  modport master (
    output IDRS, IDRT, IDUsesRT, EXRT, EXMemRead, EXMulDiv, BranchTaken,
    input  PCWrite, IFIDWrite, IDEXWrite, IFIDFlush, IDEXFlush,
           EXMEMBubble, MulDivBusy, MulDivDone, StallCycles
  );

  modport slave (
    input  IDRS, IDRT, IDUsesRT, EXRT, EXMemRead, EXMulDiv, BranchTaken,
    output PCWrite, IFIDWrite, IDEXWrite, IFIDFlush, IDEXFlush,
           EXMEMBubble, MulDivBusy, MulDivDone, StallCycles
  );
endinterface

`default_nettype wire

// File: rtl/hazard_stall_controller.sv
// ============================================================================
// Module      : hazard_stall_controller
// Description : Pipeline sequencing controller. Inserts a one-cycle bubble on
//               load-use hazards, freezes the front end while a multi-cycle
//               mul/div occupies EX, and flushes IF/ID and ID/EX on a taken
//               branch resolved in EX.
//               Optional macro HAZ_PERF_CNT_EN builds a saturating 32-bit
//               stall-cycle counter on StallCycles; otherwise it reads 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_stall_controller #(
  parameter int MULDIV_LAT = 4,  // total EX occupancy of a mul/div op (2..16)
  parameter int CNT_W      = 4   // width of the busy countdown counter
) (
  input  wire logic                 clk_i,
  input  wire logic                 rst_i,  // asynchronous, active-low
  hazard_stall_controller_if.slave  bus
);

  // Configuration sanity: the first EX cycle is handled in IDLE, so at least
  // one BUSY cycle must follow, and the reload value must fit the counter.
  if (MULDIV_LAT < 2) begin : g_bad_lat
    $error("hazard_stall_controller: MULDIV_LAT must be >= 2");
  end
  if ((MULDIV_LAT - 2) >= (2 ** CNT_W)) begin : g_bad_cnt_w
    $error("hazard_stall_controller: CNT_W too narrow for MULDIV_LAT");
  end

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Countdown reload: the IDLE cycle plus MULDIV_LAT-1 BUSY cycles, with the
  // last BUSY cycle at count zero.
  localparam logic [CNT_W-1:0] c_lat_load = CNT_W'(MULDIV_LAT - 2);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use;

  // Load in EX writes a register the ID instruction reads; $zero is exempt.
  assign load_use = bus.EXMemRead && (bus.EXRT != 5'd0) &&
                    ((bus.EXRT == bus.IDRS) ||
                     (bus.IDUsesRT && (bus.EXRT == bus.IDRT)));

  // State and busy countdown registers; reset aborts any op in flight.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic and prioritised freeze/flush outputs.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    bus.PCWrite     = 1'b1;
    bus.IFIDWrite   = 1'b1;
    bus.IDEXWrite   = 1'b1;
    bus.IFIDFlush   = 1'b0;
    bus.IDEXFlush   = 1'b0;
    bus.EXMEMBubble = 1'b0;
    bus.MulDivBusy  = 1'b0;
    bus.MulDivDone  = 1'b0;

    if (state_q == ST_BUSY) begin
      // EX is held, so branch and load-use indications are stale and ignored.
      bus.PCWrite     = 1'b0;
      bus.IFIDWrite   = 1'b0;
      bus.IDEXWrite   = 1'b0;
      bus.EXMEMBubble = 1'b1;
      bus.MulDivBusy  = 1'b1;
      if (cnt_q == '0) begin
        bus.MulDivDone = 1'b1;
        state_d        = ST_IDLE;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end else if (bus.EXMulDiv) begin
      // First EX cycle of the op: freeze now, report busy from next cycle.
      bus.PCWrite     = 1'b0;
      bus.IFIDWrite   = 1'b0;
      bus.IDEXWrite   = 1'b0;
      bus.EXMEMBubble = 1'b1;
      state_d         = ST_BUSY;
      cnt_d           = c_lat_load;
    end else if (bus.BranchTaken) begin
      // Redirect wins over load-use: the dependent instruction is squashed.
      bus.IFIDFlush = 1'b1;
      bus.IDEXFlush = 1'b1;
    end else if (load_use) begin
      bus.PCWrite   = 1'b0;
      bus.IFIDWrite = 1'b0;
      bus.IDEXFlush = 1'b1;
    end

    // While reset is held the pipeline sees the idle control pattern.
    if (!rst_i) begin
      bus.PCWrite     = 1'b1;
      bus.IFIDWrite   = 1'b1;
      bus.IDEXWrite   = 1'b1;
      bus.IFIDFlush   = 1'b0;
      bus.IDEXFlush   = 1'b0;
      bus.EXMEMBubble = 1'b0;
      bus.MulDivBusy  = 1'b0;
      bus.MulDivDone  = 1'b0;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_q;

  // Saturating count of cycles in which the PC is held.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
    end else if (!bus.PCWrite && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign bus.StallCycles = stall_cnt_q;
`else
  assign bus.StallCycles = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_controller.sv
// ============================================================================
// Module      : tb_hazard_stall_controller
// Description : Self-checking bench for hazard_stall_controller (MULDIV_LAT=4)
//               using a table of directed vectors plus hand-written sequences
//               for mul/div freeze, reset mid-op and the stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_stall_controller;

  logic clk;
  logic rst_n;

  hazard_stall_controller_if bus ();

  hazard_stall_controller #(
    .MULDIV_LAT (4),
    .CNT_W      (4)
  ) u_dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output pattern order:
  // {PCWrite, IFIDWrite, IDEXWrite, IFIDFlush, IDEXFlush, EXMEMBubble,
  //  MulDivBusy, MulDivDone}
  localparam logic [7:0] c_IDLE   = 8'b1110_0000;
  localparam logic [7:0] c_LDUSE  = 8'b0010_1000;
  localparam logic [7:0] c_BRANCH = 8'b1111_1000;
  localparam logic [7:0] c_FRZ0   = 8'b0000_0100;
  localparam logic [7:0] c_BUSY   = 8'b0000_0110;
  localparam logic [7:0] c_DONE   = 8'b0000_0111;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic [4:0] exrt;
    logic       memread;
    logic       branch;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [11];

  int n_vec  = 0;
  int n_fail = 0;

  function automatic logic [7:0] outs();
    return {bus.PCWrite, bus.IFIDWrite, bus.IDEXWrite, bus.IFIDFlush,
            bus.IDEXFlush, bus.EXMEMBubble, bus.MulDivBusy, bus.MulDivDone};
  endfunction

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                       input logic [4:0] exrt, input logic memread,
                       input logic muldiv, input logic branch);
    bus.IDRS        = rs;
    bus.IDRT        = rt;
    bus.IDUsesRT    = uses_rt;
    bus.EXRT        = exrt;
    bus.EXMemRead   = memread;
    bus.EXMulDiv    = muldiv;
    bus.BranchTaken = branch;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{rs:5'd0,  rt:5'd0,  uses_rt:1'b0, exrt:5'd0,  memread:1'b0, branch:1'b0, exp:c_IDLE};
    vecs[1]  = '{rs:5'd5,  rt:5'd9,  uses_rt:1'b0, exrt:5'd5,  memread:1'b1, branch:1'b0, exp:c_LDUSE};
    vecs[2]  = '{rs:5'd5,  rt:5'd9,  uses_rt:1'b0, exrt:5'd5,  memread:1'b0, branch:1'b0, exp:c_IDLE};
    vecs[3]  = '{rs:5'd3,  rt:5'd7,  uses_rt:1'b0, exrt:5'd7,  memread:1'b1, branch:1'b0, exp:c_IDLE};
    vecs[4]  = '{rs:5'd3,  rt:5'd7,  uses_rt:1'b1, exrt:5'd7,  memread:1'b1, branch:1'b0, exp:c_LDUSE};
    vecs[5]  = '{rs:5'd0,  rt:5'd4,  uses_rt:1'b0, exrt:5'd0,  memread:1'b1, branch:1'b0, exp:c_IDLE};
    vecs[6]  = '{rs:5'd2,  rt:5'd0,  uses_rt:1'b1, exrt:5'd0,  memread:1'b1, branch:1'b0, exp:c_IDLE};
    vecs[7]  = '{rs:5'd5,  rt:5'd9,  uses_rt:1'b0, exrt:5'd5,  memread:1'b1, branch:1'b1, exp:c_BRANCH};
    vecs[8]  = '{rs:5'd1,  rt:5'd2,  uses_rt:1'b1, exrt:5'd3,  memread:1'b0, branch:1'b1, exp:c_BRANCH};
    vecs[9]  = '{rs:5'd31, rt:5'd1,  uses_rt:1'b0, exrt:5'd31, memread:1'b1, branch:1'b0, exp:c_LDUSE};
    vecs[10] = '{rs:5'd6,  rt:5'd5,  uses_rt:1'b0, exrt:5'd5,  memread:1'b1, branch:1'b0, exp:c_IDLE};

    // Reset with a load-use pattern on the inputs: outputs must stay idle.
    drive(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    chk8("reset_outputs", outs(), c_IDLE);
    chk32("reset_stallcycles", bus.StallCycles, 32'd0);
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    #2;
    chk8("after_reset", outs(), c_IDLE);

    // Table-driven combinational vectors (state stays IDLE throughout).
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive(vecs[i].rs, vecs[i].rt, vecs[i].uses_rt, vecs[i].exrt,
            vecs[i].memread, 1'b0, vecs[i].branch);
      #2;
      chk8($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Mul/div freeze: cycles 0..3 frozen, busy 1..3, done in 3, free in 4.
    @(negedge clk);
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    #2; chk8("muldiv_c0", outs(), c_FRZ0);
    @(negedge clk);
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #2; chk8("muldiv_c1", outs(), c_BUSY);
    @(negedge clk);
    drive(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1);  // ignored while busy
    #2; chk8("muldiv_c2_ignore", outs(), c_BUSY);
    @(negedge clk);
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #2; chk8("muldiv_c3_done", outs(), c_DONE);
    @(negedge clk);
    #2; chk8("muldiv_c4_free", outs(), c_IDLE);

    // Reset asserted in cycle 2 of a mul/div: abort, no done pulse.
    @(negedge clk);
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    #2; chk8("abort_c0", outs(), c_FRZ0);
    @(negedge clk);
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #2; chk8("abort_c1", outs(), c_BUSY);
    @(negedge clk);
    #2; chk8("abort_c2", outs(), c_BUSY);
    rst_n = 1'b0;
    #1; chk8("abort_in_reset", outs(), c_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #2; chk8($sformatf("abort_post%0d", c), outs(), c_IDLE);
      @(negedge clk);
    end

    // Stall counter: one load-use stall plus one 4-cycle mul/div.
    do_reset();
    drive(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    drive(5'd0, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);  // branch-only cycles later
    repeat (3) @(negedge clk);
    @(negedge clk);
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #2;
`ifdef HAZ_PERF_CNT_EN
    chk32("stall_cycles", bus.StallCycles, 32'd5);
`else
    chk32("stall_cycles", bus.StallCycles, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Pipeline sequencing controller for the 5-stage CPU; sits beside the forwarding unit and covers the hazards that forwarding cannot resolve.
- Detects load-use hazards and inserts a one-cycle bubble.
- Freezes the front end while a multi-cycle mul/div occupies EX.
- Flushes IF/ID and ID/EX on a taken branch resolved in EX.

Parameters:
- MULDIV_LAT, 4, total EX occupancy in cycles of a mul/div op (legal 2..16)
- CNT_W, 4, width of the internal busy countdown counter

Ports:
- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  asynchronous, active-low reset
- IDRS  input  5  rs field of the instruction in ID
- IDRT  input  5  rt field of the instruction in ID
- IDUsesRT  input  1  ID instruction reads rt as a source
- EXRT  input  5  rt (load destination) of the instruction in EX
- EXMemRead  input  1  instruction in EX is a load
- EXMulDiv  input  1  instruction in EX is a mul/div, first EX cycle
- BranchTaken  input  1  branch in EX resolved taken
- PCWrite  output  1  PC update enable
- IFIDWrite  output  1  IF/ID register enable
- IDEXWrite  output  1  ID/EX register enable
- IFIDFlush  output  1  clear IF/ID to NOP
- IDEXFlush  output  1  load NOP into ID/EX (bubble)
- EXMEMBubble  output  1  load NOP into EX/MEM
- MulDivBusy  output  1  FSM in BUSY state
- MulDivDone  output  1  one-cycle pulse in the last busy cycle
- StallCycles  output  32  stall-cycle performance counter (see Optional Feature)

Behaviour:
- Reset (rst_i=0, asynchronous): FSM=IDLE, counter=0, StallCycles=0.
- Outputs during and directly after reset: PCWrite=1, IFIDWrite=1, IDEXWrite=1, all flush/bubble/busy/done outputs=0.
- FSM states: IDLE and BUSY.
- IDLE, EXMulDiv=1: next state BUSY, counter loaded with MULDIV_LAT-2.
- IDLE, otherwise: stay in IDLE.
- BUSY: counter decrements each cycle. MulDivDone=1 when counter==0; the next state is then IDLE.
- Busy occupancy: EXMulDiv cycle plus MULDIV_LAT-1 BUSY cycles, for a total of MULDIV_LAT.
- The freeze outputs below are combinational from the current state and inputs. Priority, highest first:
  1. BUSY: PCWrite=0, IFIDWrite=0, IDEXWrite=0, EXMEMBubble=1, MulDivBusy=1. BranchTaken, EXMemRead and EXMulDiv are ignored, because EX is held.
  2. IDLE and EXMulDiv=1, first cycle: same freeze as BUSY. MulDivBusy stays 0 until the next cycle.
  3. BranchTaken=1: IFIDFlush=1, IDEXFlush=1, PCWrite=1 (redirect). Any load-use result is discarded.
  4. Load-use: EXMemRead && EXRT!=0 && (EXRT==IDRS || (IDUsesRT && EXRT==IDRT)). Response: PCWrite=0, IFIDWrite=0, IDEXFlush=1 for exactly one cycle. On the next cycle the load is in MEM, so the condition clears by itself.
  5. Otherwise: all enables=1, all flush/bubble outputs=0.
- Register 0 never causes a load-use stall.
- Reset asserted mid-BUSY: the op is aborted immediately, FSM goes to IDLE, and no MulDivDone is produced.
- MULDIV_LAT < 2 is a configuration error, flagged by a simulation-only check.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- Defined: StallCycles increments by 1, saturating at 32'hFFFF_FFFF, on every cycle where PCWrite==0. Flush-only cycles are not counted. Reset clears it to 0.
- Undefined: StallCycles is tied to 32'd0 and no counter flops are built.

Test Plan:
- Load-use on rs: EXMemRead=1, EXRT=5, IDRS=5 -> PCWrite=0, IFIDWrite=0, IDEXFlush=1 for 1 cycle; with EXMemRead=0 next cycle, all outputs return to idle values.
- rt source and $zero: EXRT=7, IDRT=7, IDUsesRT=0 -> no stall; IDUsesRT=1 -> stall. EXRT=0, IDRS=0 -> no stall.
- Mul/div, MULDIV_LAT=4: EXMulDiv=1 at cycle 0 -> freeze in cycles 0..3, MulDivBusy=1 in cycles 1..3, MulDivDone=1 in cycle 3 only, PCWrite=1 in cycle 4.
- Branch with load-use: BranchTaken=1 and a load-use match in the same cycle -> IFIDFlush=1, IDEXFlush=1, PCWrite=1, IFIDWrite=1.
- Reset mid-op: drop rst_i in cycle 2 of a BUSY sequence -> outputs immediately at reset values, MulDivDone never pulses, FSM=IDLE after release.
- HAZ_PERF_CNT_EN defined: one load-use stall plus one MULDIV_LAT=4 op -> StallCycles=5. Macro undefined -> StallCycles=0.
